truth_table_checker: RTL and testbench

- Sequential stimulus/response checker for small combinational circuits under test (CUT) with N_IN inputs and one output.
- On start, sweeps every input combination 0 .. 2^N_IN-1 onto the CUT inputs, waits a settle time, then samples the CUT output.
- Compares each sample against a latched expected-minterm mask and reports the error count, the first failing index and pass/fail.
- It is the hardware counterpart of the exhaustive truth-table sweeps the team runs in benches, so CUT modules can be self-checked in synthesised form.

---
 rtl/tt_pkg.sv | 5 +
 rtl/truth_table_checker_if.sv | 17 +
 rtl/tt_settle_timer.sv | 18 +
 rtl/truth_table_checker.sv | 65 ++++++
 tb/tb_truth_table_checker.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding and settle-counter width for the truth-table checker.
package tt_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    localparam int SETTLE_W = 8;
endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: control, CUT drive/sense and result signals of the checker.
interface truth_table_checker_if #(parameter int N_IN = 4);
    logic                   start;
    logic [(1<<N_IN)-1:0]   expected;
    logic [N_IN-1:0]        dut_in;
    logic                   dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic                   first_err_valid;
    logic [N_IN-1:0]        first_err_idx;
    modport master (output start, expected, dut_out,
                    input dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx);
    modport slave  (input start, expected, dut_out,
                    output dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx);
endinterface

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: reloadable down-counter timing the settle wait; expire fires on load when SETTLE=0.
module tt_settle_timer import tt_pkg::*; #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    logic [SETTLE_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= SETTLE_W'(SETTLE);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expire = load ? (SETTLE == 0) : (cnt == SETTLE_W'(1));
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all CUT input vectors, samples the output after a settle wait
// and compares against a latched expected-minterm mask.
module truth_table_checker import tt_pkg::*; #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic reset,
    truth_table_checker_if.slave bus
);
    localparam int NV = 1 << N_IN;
    state_t state, state_nxt;
    logic [NV-1:0]   mask;
    logic [N_IN-1:0] idx;
    logic accept, last, miss, load, expire;
    assign accept = (state == S_IDLE) && bus.start;
    assign last   = idx == {N_IN{1'b1}};
    assign miss   = bus.dut_out != mask[idx];
    assign load   = accept || (state == S_SAMPLE && !last);
    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk(clk), .reset(reset), .load(load), .en(state == S_SETTLE), .expire(expire)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (load) state_nxt = expire ? S_SAMPLE : S_SETTLE;
        else if (state == S_SETTLE && expire) state_nxt = S_SAMPLE;
        else if (state == S_SAMPLE) state_nxt = S_DONE;
        else if (state == S_DONE) state_nxt = S_IDLE;
    end
    assign bus.dut_in = idx;
    assign bus.busy   = state != S_IDLE;
    assign bus.done   = state == S_DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask                <= '0;
            idx                 <= '0;
            bus.err_count       <= '0;
            bus.first_err_valid <= 1'b0;
            bus.first_err_idx   <= '0;
            bus.pass            <= 1'b0;
        end else if (accept) begin
            mask                <= bus.expected;
            idx                 <= '0;
            bus.err_count       <= '0;
            bus.first_err_valid <= 1'b0;
            bus.first_err_idx   <= '0;
            bus.pass            <= 1'b0;
        end else if (state == S_SAMPLE) begin
            if (miss) begin
                bus.err_count <= bus.err_count + 1'b1;
                if (!bus.first_err_valid) begin
                    bus.first_err_valid <= 1'b1;
                    bus.first_err_idx   <= idx;
                end
            end
            // pass must account for the final sample, which lands in the same edge
            if (last) bus.pass <= (bus.err_count == '0) && !miss;
            else idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: table-driven, hand-sequenced and random checks of truth_table_checker.
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] cut_tt = 16'hAAAA;
    logic start_s = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(4)) bus ();
    truth_table_checker_if #(.N_IN(4)) b3 ();
    truth_table_checker_if #(.N_IN(4)) b0 ();

    truth_table_checker #(.N_IN(4), .SETTLE(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    truth_table_checker #(.N_IN(4), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));
    truth_table_checker #(.N_IN(4), .SETTLE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    assign bus.dut_out = cut_tt[bus.dut_in];
    assign b3.dut_out  = b3.dut_in[0];
    assign b0.dut_out  = b0.dut_in[0];
    assign b3.start    = start_s;
    assign b0.start    = start_s;
    assign b3.expected = 16'hAAAA;
    assign b0.expected = 16'hAAAA;

    typedef struct {
        logic [15:0] cut;
        logic [15:0] exp_m;
        int err;
        int fidx;
        int fv;
        int pass;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_results(input string tag, input int err, input int fidx, input int fv, input int pass);
        chk({tag, " err_count"}, int'(bus.err_count), err);
        chk({tag, " first_err_idx"}, int'(bus.first_err_idx), fidx);
        chk({tag, " first_err_valid"}, int'(bus.first_err_valid), fv);
        chk({tag, " pass"}, int'(bus.pass), pass);
    endtask

    // Starts a sweep (edge 0 = acceptance) and observes 36 further edges.
    task automatic sweep(input logic [15:0] cut, input logic [15:0] exp_m, input bit glitch,
                         output int done_edge, output int ndone, output int traj_bad);
        cut_tt = cut;
        bus.expected = exp_m;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_edge = -1; ndone = 0; traj_bad = 0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin ndone++; done_edge = k; end
            if (k <= 32 && int'(bus.dut_in) != (k < 32 ? k / 2 : 15)) traj_bad++;
            if (glitch) begin
                bus.start = (k == 4 || k == 19);
                if (k == 10) bus.expected = ~exp_m;
            end
        end
        bus.start = 1'b0;
    endtask

    function automatic int model_err(input logic [15:0] cut, input logic [15:0] exp_m);
        return $countones(cut ^ exp_m);
    endfunction

    function automatic int model_fidx(input logic [15:0] cut, input logic [15:0] exp_m);
        logic [15:0] d;
        d = cut ^ exp_m;
        for (int i = 0; i < 16; i++) if (d[i]) return i;
        return 0;
    endfunction

    initial begin
        int de, nd, tb_bad, e, d0, d3, s0, s3;
        logic [15:0] rc, re;
        tbl[0] = '{16'hAAAA, 16'hAAAA, 0, 0, 0, 1};
        tbl[1] = '{16'hAAAA, 16'hAAAB, 1, 0, 1, 0};
        tbl[2] = '{16'hAAAA, 16'h5555, 16, 0, 1, 0};
        tbl[3] = '{16'hAAAA, 16'h2AAA, 1, 15, 1, 0};
        tbl[4] = '{16'hAAAA, 16'hAAA8, 1, 1, 1, 0};
        tbl[5] = '{16'hFFFF, 16'h0000, 16, 0, 1, 0};
        bus.start = 1'b0;
        bus.expected = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset dut_in", int'(bus.dut_in), 0);
        chk_results("reset", 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            sweep(tbl[i].cut, tbl[i].exp_m, 1'b0, de, nd, tb_bad);
            chk($sformatf("tbl%0d done_edge", i), de, 32);
            chk($sformatf("tbl%0d done_count", i), nd, 1);
            chk($sformatf("tbl%0d dut_in_steps", i), tb_bad, 0);
            chk_results($sformatf("tbl%0d", i), tbl[i].err, tbl[i].fidx, tbl[i].fv, tbl[i].pass);
        end

        sweep(16'hAAAA, 16'h5555, 1'b1, de, nd, tb_bad);
        chk("glitch done_edge", de, 32);
        chk("glitch done_count", nd, 1);
        chk_results("glitch", 16, 0, 1, 0);

        cut_tt = 16'hAAAA;
        bus.expected = 16'hAAAA;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k == 32) chk("hold done@32", int'(bus.done), 1);
            if (k == 33) begin
                chk("hold busy@33", int'(bus.busy), 0);
                chk("hold pass@33", int'(bus.pass), 1);
            end
        end
        @(posedge clk); #1;
        chk("hold restart busy@34", int'(bus.busy), 1);
        chk("hold restart pass cleared", int'(bus.pass), 0);
        bus.start = 1'b0;
        nd = 0;
        for (int k = 0; k < 40 && nd == 0; k++) begin
            @(posedge clk); #1;
            if (bus.done) nd = 1;
        end
        chk("hold second done", nd, 1);
        chk("hold second pass", int'(bus.pass), 1);
        @(posedge clk); #1;

        cut_tt = 16'hAAAA;
        bus.expected = 16'h5555;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 30 && bus.dut_in != 4'd5; k++) begin
            @(posedge clk); #1;
        end
        chk("abort reached dut_in=5", int'(bus.dut_in), 5);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort dut_in", int'(bus.dut_in), 0);
        chk("abort done", int'(bus.done), 0);
        chk_results("abort", 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        chk("abort no done", nd, 0);
        sweep(16'hAAAA, 16'hAAAA, 1'b0, de, nd, tb_bad);
        chk("post-abort done_edge", de, 32);
        chk("post-abort steps", tb_bad, 0);
        chk_results("post-abort", 0, 0, 0, 1);

        for (int r = 0; r < 12; r++) begin
            rc = 16'($urandom);
            re = (r % 3 == 0) ? rc : (r % 3 == 1) ? rc ^ (16'h1 << $urandom_range(15)) : 16'($urandom);
            sweep(rc, re, 1'b0, de, nd, tb_bad);
            e = model_err(rc, re);
            chk($sformatf("rand%0d done_edge", r), de, 32);
            chk_results($sformatf("rand%0d", r), e, model_fidx(rc, re), int'(e != 0), int'(e == 0));
        end

        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        d0 = -1; d3 = -1; s0 = -1; s3 = -1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            if (b0.done && d0 < 0) d0 = k;
            if (b3.done && d3 < 0) d3 = k;
            if (b0.dut_in == 4'd8 && s0 < 0) s0 = k;
            if (b3.dut_in == 4'd8 && s3 < 0) s3 = k;
        end
        chk("settle0 done_edge", d0, 16);
        chk("settle3 done_edge", d3, 64);
        chk("settle0 vec7 sample edge", s0, 8);
        chk("settle3 vec7 sample edge", s3, 32);
        chk("settle0 pass", int'(b0.pass), 1);
        chk("settle3 pass", int'(b3.pass), 1);
        chk("settle3 err_count", int'(b3.err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
